// File: rtl/amo_sequencer.sv
// rtl/amo_sequencer.sv - LR/SC/AMO request sequencer driving the memory port and atomic unit agent port
module amo_sequencer #(
    parameter int ID_W = 4,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_kind,
    input  logic [OP_W-1:0] req_op,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_data,
    input  logic [ID_W-1:0] req_id,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic            set_reservation,
    output logic            clear_reservation,
    output logic [31:0]     reservation,
    input  logic            reservation_valid,
    output logic            rmw_valid,
    output logic [OP_W-1:0] op,
    output logic [31:0]     rs1,
    output logic [31:0]     rs2,
    input  logic [31:0]     rd,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic [ID_W-1:0] rsp_id
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_ALU    = 3'd2,
        S_WR     = 3'd3,
        S_SC_CHK = 3'd4,
        S_RSP    = 3'd5
    } state_t;

    localparam logic [1:0] KIND_LR = 2'd0;
    localparam logic [1:0] KIND_SC = 2'd1;

    state_t          state;
    state_t          state_nxt;
    logic            live;
    logic [1:0]      kind_q;
    logic [OP_W-1:0] op_q;
    logic [31:0]     addr_q;
    logic [31:0]     data_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     old_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rsp_data_q;
    logic            accept;
    logic            is_lr;
    logic [31:0]     word_addr;

    // LR finishes straight after its read; anything not LR/SC is an AMO
    assign is_lr     = (kind_q == KIND_LR);
    assign accept    = req_valid && live && (state == S_IDLE);
    assign word_addr = {addr_q[31:2], 2'b00};

    // The reservation address tracks the captured request address at all times
    assign reservation = addr_q;

    // State register; reset abandons any in-flight memory access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Keeps req_ready low while reset is asserted and until the first clock after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Request capture plus old value, write data and response data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q     <= 2'd0;
            op_q       <= '0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            id_q       <= '0;
            old_q      <= 32'd0;
            wdata_q    <= 32'd0;
            rsp_data_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        kind_q <= req_kind;
                        op_q   <= req_op;
                        addr_q <= req_addr;
                        data_q <= req_data;
                        id_q   <= req_id;
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        old_q <= mem_rdata;
                        if (is_lr) begin
                            rsp_data_q <= mem_rdata;
                        end
                    end
                end
                S_ALU: begin
                    wdata_q    <= rd;
                    rsp_data_q <= old_q;
                end
                S_SC_CHK: begin
                    if (reservation_valid) begin
                        wdata_q    <= data_q;
                        rsp_data_q <= 32'd0;
                    end else begin
                        rsp_data_q <= 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode; every output is zero outside the state that drives it
    always_comb begin
        state_nxt         = state;
        req_ready         = 1'b0;
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        mem_addr          = 32'd0;
        mem_wdata         = 32'd0;
        set_reservation   = 1'b0;
        clear_reservation = 1'b0;
        rmw_valid         = 1'b0;
        op                = '0;
        rs1               = 32'd0;
        rs2               = 32'd0;
        rsp_valid         = 1'b0;
        rsp_data          = 32'd0;
        rsp_id            = '0;
        case (state)
            S_IDLE: begin
                req_ready = live;
                if (accept) begin
                    case (req_kind)
                        KIND_LR: state_nxt = S_RD;
                        KIND_SC: state_nxt = S_SC_CHK;
                        default: state_nxt = S_RD;
                    endcase
                end
            end
            S_RD: begin
                mem_req  = 1'b1;
                mem_addr = word_addr;
                if (mem_ack) begin
                    if (is_lr) begin
                        set_reservation = 1'b1;
                        state_nxt       = S_RSP;
                    end else begin
                        state_nxt = S_ALU;
                    end
                end
            end
            S_ALU: begin
                rmw_valid = 1'b1;
                op        = op_q;
                rs1       = old_q;
                rs2       = data_q;
                state_nxt = S_WR;
            end
            S_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = wdata_q;
                if (mem_ack) begin
                    state_nxt = S_RSP;
                end
            end
            S_SC_CHK: begin
                clear_reservation = 1'b1;
                state_nxt         = reservation_valid ? S_WR : S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                rsp_data  = rsp_data_q;
                rsp_id    = id_q;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_amo_sequencer.sv
// tb/tb_amo_sequencer.sv - randomized self-checking bench for amo_sequencer
module tb_amo_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [4:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_id;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        set_reservation;
    logic        clear_reservation;
    logic [31:0] reservation;
    logic        reservation_valid;
    logic        rmw_valid;
    logic [4:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_id;

    amo_sequencer #(.ID_W(4), .OP_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_id(req_id),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .set_reservation(set_reservation), .clear_reservation(clear_reservation),
        .reservation(reservation), .reservation_valid(reservation_valid),
        .rmw_valid(rmw_valid), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Atomic unit ALU behaviour by funct5
    function automatic logic [31:0] amo_calc(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            5'b00000: return a + b;
            5'b00001: return b;
            5'b00100: return a ^ b;
            5'b01100: return a & b;
            5'b01000: return a | b;
            5'b10000: return ($signed(a) < $signed(b)) ? a : b;
            5'b10100: return ($signed(a) > $signed(b)) ? a : b;
            5'b11000: return (a < b) ? a : b;
            5'b11100: return (a > b) ? a : b;
            default:  return a + b;
        endcase
    endfunction

    assign rd = amo_calc(op, rs1, rs2);

    // Memory seen by the DUT, and the model's view of what it must contain
    logic [31:0] env_mem   [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : (a ^ 32'h5A5A_1234);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : (a ^ 32'h5A5A_1234);
    endfunction

    // Memory responder: ack after a chosen latency, optional stray acks when idle
    int ack_delay = 0;
    bit spur_en   = 1'b0;
    int cnt       = 0;
    int lat       = 0;

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            mem_ack = 1'b0;
            cnt     = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            cnt     = 0;
        end else if (mem_req) begin
            if (cnt == 0) lat = (ack_delay < 0) ? int'($urandom % 4) : ack_delay;
            if (cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? $urandom : env_rd(mem_addr);
            end else begin
                cnt++;
            end
        end else begin
            cnt = 0;
            if (spur_en && ($urandom % 6 == 0)) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    // Expected transaction, set by the driver once a request is accepted
    bit          exp_active = 1'b0;
    logic [1:0]  exp_kind;
    logic [31:0] exp_addr, exp_a, exp_data, exp_old, exp_wdata, exp_rsp;
    logic [4:0]  exp_op;
    logic [3:0]  exp_id;
    bit          exp_r, exp_w;
    int          n_rd, n_wr, n_set, n_clr, n_rmw;
    logic        prev_wait = 1'b0;
    logic [33:0] prev_bus;

    // Compare process: checks outputs against the expected transaction every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            check("set_clr_excl", {63'd0, set_reservation & clear_reservation}, 64'd0);
            if (prev_wait) check("mem_hold", {30'd0, mem_req, mem_we, mem_addr}, {30'd0, prev_bus});
            if (exp_active) begin
                check("req_ready_busy", {63'd0, req_ready}, 64'd0);
                check("reservation", {32'd0, reservation}, {32'd0, exp_addr});
                if (mem_req) begin
                    check("mem_addr", {32'd0, mem_addr}, {32'd0, exp_a});
                    check("mem_dir_allowed", {63'd0, mem_we ? exp_w : exp_r}, 64'd1);
                    if (mem_we) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, exp_wdata});
                    if (mem_ack) begin
                        if (mem_we) begin
                            n_wr++;
                            env_mem[mem_addr] = mem_wdata;
                        end else begin
                            n_rd++;
                        end
                    end
                end
                if (set_reservation) begin
                    n_set++;
                    check("set_on_read_ack", {63'd0, mem_req & mem_ack & ~mem_we}, 64'd1);
                end
                if (clear_reservation) n_clr++;
                if (rmw_valid) begin
                    n_rmw++;
                    check("rs1", {32'd0, rs1}, {32'd0, exp_old});
                    check("rs2", {32'd0, rs2}, {32'd0, exp_data});
                    check("op", {59'd0, op}, {59'd0, exp_op});
                end
                if (rsp_valid) begin
                    check("rsp_data", {32'd0, rsp_data}, {32'd0, exp_rsp});
                    check("rsp_id", {60'd0, rsp_id}, {60'd0, exp_id});
                end
            end
        end
        prev_wait = rst_n && mem_req && !mem_ack;
        prev_bus  = {mem_req, mem_we, mem_addr};
    end

    logic [207:0] all_out;
    assign all_out = {req_ready, mem_req, mem_we, mem_addr, mem_wdata, set_reservation,
                      clear_reservation, reservation, rmw_valid, op, rs1, rs2,
                      rsp_valid, rsp_data, rsp_id};

    logic [31:0] last_rsp;

    // One complete request/response transaction checked against the model
    task automatic do_req(input logic [1:0] k, input logic [4:0] o, input logic [31:0] ad,
                          input logic [31:0] dt, input logic [3:0] idv, input bit ok, input int hold);
        int n;
        int exp_lat;
        bit got;
        logic [31:0] nv;
        repeat (2) @(negedge clk);
        exp_kind = k;
        exp_addr = ad;
        exp_a    = {ad[31:2], 2'b00};
        exp_data = dt;
        exp_op   = o;
        exp_id   = idv;
        exp_old  = model_rd(exp_a);
        exp_r    = 1'b0;
        exp_w    = 1'b0;
        nv       = exp_old;
        if (k == 2'd0) begin
            exp_rsp = exp_old; exp_r = 1'b1; exp_lat = 2;
        end else if (k == 2'd1) begin
            if (ok) begin
                exp_rsp = 32'd0; exp_w = 1'b1; exp_wdata = dt; nv = dt; exp_lat = 3;
            end else begin
                exp_rsp = 32'd1; exp_lat = 2;
            end
        end else begin
            exp_rsp = exp_old; exp_r = 1'b1; exp_w = 1'b1;
            exp_wdata = amo_calc(o, exp_old, dt); nv = exp_wdata; exp_lat = 4;
        end
        req_valid = 1'b1; req_kind = k; req_op = o; req_addr = ad; req_data = dt; req_id = idv;
        reservation_valid = ok;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_kind = 2'($urandom); req_op = 5'($urandom);
        req_addr = $urandom; req_data = $urandom; req_id = 4'($urandom);
        n_rd = 0; n_wr = 0; n_set = 0; n_clr = 0; n_rmw = 0;
        exp_active = 1'b1;
        n = 0;
        got = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("rsp_timeout", {63'd0, got}, 64'd1);
        if (got && ack_delay == 0) check("latency", 64'(n), 64'(exp_lat));
        repeat (hold) @(negedge clk);
        last_rsp = rsp_data;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_active = 1'b0;
        check("n_rd", 64'(n_rd), {63'd0, exp_r});
        check("n_wr", 64'(n_wr), {63'd0, exp_w});
        check("n_set", 64'(n_set), (k == 2'd0) ? 64'd1 : 64'd0);
        check("n_clr", 64'(n_clr), (k == 2'd1) ? 64'd1 : 64'd0);
        check("n_rmw", 64'(n_rmw), (k[1]) ? 64'd1 : 64'd0);
        model_mem[exp_a] = nv;
        check("mem_contents", {32'd0, env_rd(exp_a)}, {32'd0, model_rd(exp_a)});
    endtask

    logic [4:0] ops [9] = '{5'b00000, 5'b00001, 5'b00100, 5'b01100, 5'b01000,
                             5'b10000, 5'b10100, 5'b11000, 5'b11100};

    initial begin
        int n;
        logic [31:0] saved;
        rst_n = 1'b0; req_valid = 1'b0; req_kind = 2'd0; req_op = 5'd0; req_addr = 32'd0;
        req_data = 32'd0; req_id = 4'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        reservation_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs_zero", {63'd0, |all_out}, 64'd0);
        #2 rst_n = 1'b1;

        check("model_amoadd", {32'd0, amo_calc(5'b00000, 32'd10, 32'd5)}, 64'd15);
        check("model_amomin", {32'd0, amo_calc(5'b10000, 32'hFFFF_FFFF, 32'd1)}, 64'hFFFF_FFFF);
        check("model_amominu", {32'd0, amo_calc(5'b11000, 32'hFFFF_FFFF, 32'd1)}, 64'd1);

        // Directed scenarios
        env_mem[32'h100] = 32'hDEAD; model_mem[32'h100] = 32'hDEAD;
        env_mem[32'h200] = 32'd10;   model_mem[32'h200] = 32'd10;
        ack_delay = 3;
        do_req(2'd0, 5'd0, 32'h100, 32'd0, 4'd9, 1'b1, 0);
        check("lr_rsp", {32'd0, last_rsp}, 64'hDEAD);
        ack_delay = 0;
        do_req(2'd1, 5'd0, 32'h100, 32'h55, 4'd3, 1'b1, 0);
        check("sc_ok_rsp", {32'd0, last_rsp}, 64'd0);
        check("sc_ok_mem", {32'd0, env_rd(32'h100)}, 64'h55);
        do_req(2'd1, 5'd0, 32'h100, 32'h77, 4'd4, 1'b0, 0);
        check("sc_fail_rsp", {32'd0, last_rsp}, 64'd1);
        check("sc_fail_mem", {32'd0, env_rd(32'h100)}, 64'h55);
        do_req(2'd2, 5'b00000, 32'h200, 32'd5, 4'd7, 1'b0, 5);
        check("amoadd_rsp", {32'd0, last_rsp}, 64'd10);
        check("amoadd_mem", {32'd0, env_rd(32'h200)}, 64'd15);

        // Reset during the write wait of an AMO
        ack_delay = 1000;
        saved = env_rd(32'h300);
        @(negedge clk);
        req_valid = 1'b1; req_kind = 2'd2; req_op = 5'd0; req_addr = 32'h300; req_data = 32'd7; req_id = 4'd1;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!(mem_req && mem_we) && n < 2000) begin @(negedge clk); n++; end
        check("reached_wr_wait", {62'd0, mem_req, mem_we}, 64'd3);
        #2 rst_n = 1'b0;
        #1 check("reset_mid_op_zero", {63'd0, |all_out}, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ack_delay = 0;
        check("reset_write_abandoned", {32'd0, env_rd(32'h300)}, {32'd0, saved});
        do_req(2'd0, 5'd0, 32'h300, 32'd0, 4'd2, 1'b1, 1);
        check("after_reset_lr", {32'd0, last_rsp}, {32'd0, saved});

        // Randomized traffic over a small address pool
        for (int i = 0; i < 200; i++) begin
            if (i % 4 == 0) begin
                ack_delay = 0; spur_en = 1'b0;
            end else begin
                ack_delay = -1; spur_en = 1'b1;
            end
            do_req(2'($urandom), ops[$urandom % 9],
                   32'h1000 + (($urandom % 8) << 2) + ($urandom % 4),
                   $urandom, 4'($urandom), 1'($urandom), int'($urandom % 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
